// File: rtl/walker_pkg.sv
// Shared types and default widths for the depth-first tree walker.
// Contents: FSM state enum, packed node word {is_leaf, left, right, rule},
// default width constants and a node-building helper.
package walker_pkg;

  localparam int IDX_W_DEF  = 8;
  localparam int RULE_W_DEF = 16;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [3:0] {
    IDLE,
    PUSH_ROOT,
    POP,
    POP_WAIT,
    MEM_REQ,
    MEM_WAIT,
    EMIT,
    PUSH_R,
    PUSH_L,
    DONE
  } state_t;

  // Field order matches the memory response word, MSB first.
  typedef struct packed {
    logic                  is_leaf;
    logic [IDX_W_DEF-1:0]  left;
    logic [IDX_W_DEF-1:0]  right;
    logic [RULE_W_DEF-1:0] rule;
  } node_t;

  function automatic node_t mk_node(input logic                  is_leaf,
                                    input logic [IDX_W_DEF-1:0]  left,
                                    input logic [IDX_W_DEF-1:0]  right,
                                    input logic [RULE_W_DEF-1:0] rule);
    node_t n;
    n.is_leaf = is_leaf;
    n.left    = left;
    n.right   = right;
    n.rule    = rule;
    return n;
  endfunction

endpackage

// File: rtl/dfs_walker.sv
// Depth-first walker: reads tree nodes from memory, uses an external LIFO, emits leaf rule ids.
// Latency: 4 cycles per node read plus memory latency; one request outstanding at a time.
// Backpressure: leaf_valid/leaf_rule held stable until leaf_ready; no stack or memory traffic meanwhile.
//
// Ports: clk, reset (sync, active-low); start/root_idx request a walk; stk_* drive the
//   external stack (rdata valid the cycle after pop); mem_* read one node word
//   {is_leaf,left,right,rule}; leaf_valid/leaf_ready/leaf_rule deliver leaves;
//   busy, done, err_overflow (sticky per walk), visited_cnt report status.
// Build option: WALKER_NODE_CNT_EN enables the saturating visited-node counter;
//   without it visited_cnt is constant 0 and no counter flops exist.
module dfs_walker
  import walker_pkg::*;
#(
  parameter int IDX_W  = IDX_W_DEF,
  parameter int RULE_W = RULE_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [IDX_W-1:0]          root_idx,
  output logic                      stk_push,
  output logic                      stk_pop,
  output logic [IDX_W-1:0]          stk_wdata,
  input  logic [IDX_W-1:0]          stk_rdata,
  input  logic                      stk_full,
  input  logic                      stk_empty,
  output logic                      mem_req,
  output logic [IDX_W-1:0]          mem_idx,
  input  logic                      mem_rsp_valid,
  input  logic [1+2*IDX_W+RULE_W-1:0] mem_rsp_data,
  output logic                      leaf_valid,
  input  logic                      leaf_ready,
  output logic [RULE_W-1:0]         leaf_rule,
  output logic                      busy,
  output logic                      done,
  output logic                      err_overflow,
  output logic [CNT_W-1:0]          visited_cnt
);

  localparam int NODE_W = 1 + 2*IDX_W + RULE_W;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    root_q, root_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    left_q, left_d;
  logic [IDX_W-1:0]    right_q, right_d;
  logic [RULE_W-1:0]   rule_q, rule_d;
  logic                err_q, err_d;

  // Unpack the response word; layout is {is_leaf, left, right, rule}.
  logic                rsp_leaf;
  logic [IDX_W-1:0]    rsp_left;
  logic [IDX_W-1:0]    rsp_right;
  logic [RULE_W-1:0]   rsp_rule;

  assign rsp_leaf  = mem_rsp_data[NODE_W-1];
  assign rsp_left  = mem_rsp_data[NODE_W-2 -: IDX_W];
  assign rsp_right = mem_rsp_data[RULE_W+IDX_W-1 -: IDX_W];
  assign rsp_rule  = mem_rsp_data[RULE_W-1:0];

  always_comb begin
    state_d    = state_q;
    root_d     = root_q;
    idx_d      = idx_q;
    left_d     = left_q;
    right_d    = right_q;
    rule_d     = rule_q;
    err_d      = err_q;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_wdata  = '0;
    mem_req    = 1'b0;
    mem_idx    = '0;
    leaf_valid = 1'b0;
    leaf_rule  = '0;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          root_d  = root_idx;
          err_d   = 1'b0;
          state_d = PUSH_ROOT;
        end
      end
      PUSH_ROOT: begin
        // A stack left non-empty by an aborted walk can still be full here.
        if (stk_full) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          stk_push  = 1'b1;
          stk_wdata = root_q;
          state_d   = POP;
        end
      end
      POP: begin
        if (stk_empty) begin
          state_d = DONE;
        end else begin
          stk_pop = 1'b1;
          state_d = POP_WAIT;
        end
      end
      POP_WAIT: begin
        idx_d   = stk_rdata;
        state_d = MEM_REQ;
      end
      MEM_REQ: begin
        mem_req = 1'b1;
        mem_idx = idx_q;
        state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_rsp_valid) begin
          left_d  = rsp_left;
          right_d = rsp_right;
          rule_d  = rsp_rule;
          state_d = rsp_leaf ? EMIT : PUSH_R;
        end
      end
      EMIT: begin
        leaf_valid = 1'b1;
        leaf_rule  = rule_q;
        if (leaf_ready) state_d = POP;
      end
      // Right is pushed before left so that left is popped (visited) first.
      PUSH_R: begin
        if (stk_full) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          stk_push  = 1'b1;
          stk_wdata = right_q;
          state_d   = PUSH_L;
        end
      end
      PUSH_L: begin
        if (stk_full) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          stk_push  = 1'b1;
          stk_wdata = left_q;
          state_d   = POP;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      root_q  <= '0;
      idx_q   <= '0;
      left_q  <= '0;
      right_q <= '0;
      rule_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      root_q  <= root_d;
      idx_q   <= idx_d;
      left_q  <= left_d;
      right_q <= right_d;
      rule_q  <= rule_d;
      err_q   <= err_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign err_overflow = err_q;

`ifdef WALKER_NODE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts node reads; sticks at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && start) begin
      cnt_d = '0;
    end else if (state_q == MEM_REQ && cnt_q != '1) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign visited_cnt = cnt_q;
`else
  assign visited_cnt = '0;
`endif

endmodule

// File: tb/tb_dfs_walker.sv
// Self-checking bench for dfs_walker with behavioural stack and node memory.
// Leaf rules are compared through an expected/observed queue scoreboard.
module tb_dfs_walker;
  import walker_pkg::*;

`ifdef WALKER_NODE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  root_idx = '0;
  logic        stk_push, stk_pop;
  logic [7:0]  stk_wdata;
  logic [7:0]  stk_rdata;
  logic        stk_full, stk_empty;
  logic        mem_req;
  logic [7:0]  mem_idx;
  logic        mem_rsp_valid;
  logic [32:0] mem_rsp_data;
  logic        leaf_valid;
  logic        leaf_ready = 1'b1;
  logic [15:0] leaf_rule;
  logic        busy, done, err_overflow;
  logic [15:0] visited_cnt;

  dfs_walker dut (
    .clk(clk), .reset(reset), .start(start), .root_idx(root_idx),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata),
    .stk_rdata(stk_rdata), .stk_full(stk_full), .stk_empty(stk_empty),
    .mem_req(mem_req), .mem_idx(mem_idx), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .leaf_valid(leaf_valid), .leaf_ready(leaf_ready),
    .leaf_rule(leaf_rule), .busy(busy), .done(done), .err_overflow(err_overflow),
    .visited_cnt(visited_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // ---------------- stack model (shares reset) ----------------
  int         depth = 8;
  int         sp = 0;
  logic [7:0] stk_mem [16];
  int         both_viol = 0;
  int         full_push_viol = 0;
  int         act_cnt = 0;

  assign stk_full  = (sp >= depth);
  assign stk_empty = (sp == 0);

  always @(posedge clk) begin
    if (!reset) begin
      sp        <= 0;
      stk_rdata <= '0;
    end else begin
      if (stk_push && stk_pop) both_viol <= both_viol + 1;
      if (stk_push || stk_pop || mem_req) act_cnt <= act_cnt + 1;
      if (stk_push) begin
        if (sp >= depth) full_push_viol <= full_push_viol + 1;
        else begin
          stk_mem[sp] <= stk_wdata;
          sp <= sp + 1;
        end
      end else if (stk_pop && sp > 0) begin
        stk_rdata <= stk_mem[sp-1];
        sp <= sp - 1;
      end
    end
  end

  // ---------------- node memory model, 2-cycle latency ----------------
  node_t      node_mem [256];
  int         cd = 0;
  logic [7:0] pend = '0;
  int         out_viol = 0;

  always @(posedge clk) begin
    if (!reset) begin
      cd            <= 0;
      mem_rsp_valid <= 1'b0;
      mem_rsp_data  <= '0;
    end else begin
      mem_rsp_valid <= 1'b0;
      if (mem_req) begin
        if (cd != 0) out_viol <= out_viol + 1;
        pend <= mem_idx;
        cd   <= 2;
      end else if (cd == 1) begin
        mem_rsp_valid <= 1'b1;
        mem_rsp_data  <= node_mem[pend];
        cd <= 0;
      end else if (cd > 1) begin
        cd <= cd - 1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [15:0] exp_q [$];
  logic [15:0] got_q [$];
  int          done_cnt = 0;
  int          done_dbl = 0;
  logic        prev_done = 1'b0;
  logic [15:0] done_visited = '0;
  logic        done_err = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      if (leaf_valid && leaf_ready) got_q.push_back(leaf_rule);
      if (done) begin
        done_cnt     <= done_cnt + 1;
        done_visited <= visited_cnt;
        done_err     <= err_overflow;
      end
      if (done && prev_done) done_dbl <= done_dbl + 1;
      prev_done <= done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  function automatic logic [15:0] exp_cnt(input int n);
    return CNT_EN ? 16'(n) : 16'd0;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic apply_reset();
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic pulse_start(input logic [7:0] r);
    @(posedge clk); #1 start = 1'b1; root_idx = r;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int d0, output bit timed_out);
    int c;
    c = 0;
    while (done_cnt == d0 && c < 2000) begin
      @(posedge clk);
      c++;
    end
    timed_out = (done_cnt == d0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy);
    else n_pass++;
    n_chk++;
    if ({stk_push, stk_pop, stk_wdata, mem_req, mem_idx, leaf_valid, leaf_rule,
         done, err_overflow, visited_cnt} !== '0)
      $display("FAIL reset_outputs push=%b pop=%b wd=%h req=%b idx=%h lv=%b lr=%h done=%b err=%b cnt=%h want all 0",
               stk_push, stk_pop, stk_wdata, mem_req, mem_idx, leaf_valid, leaf_rule,
               done, err_overflow, visited_cnt);
    else n_pass++;
    #1 reset = 1'b1;
  endtask

  task automatic test_single_leaf();
    int d0; bit to; logic [15:0] e, g;
    d0 = done_cnt;
    exp_q.push_back(16'h00AA);
    pulse_start(8'd3);
    wait_done(d0, to);
    n_chk++;
    if (to) $display("FAIL single_timeout got=no_done want=done");
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (got_q.size() == 0) $display("FAIL single_leaf got=none want=%h", e);
      else begin
        g = got_q.pop_front();
        if (g !== e) $display("FAIL single_leaf got=%h want=%h", g, e);
        else n_pass++;
      end
    end
    n_chk++;
    if (got_q.size() != 0) $display("FAIL single_extra got=%0d want=0", got_q.size());
    else n_pass++;
    n_chk++;
    if (done_visited !== exp_cnt(1)) $display("FAIL single_cnt got=%0d want=%0d", done_visited, exp_cnt(1));
    else n_pass++;
    n_chk++;
    if (done_err !== 1'b0) $display("FAIL single_err got=%b want=0", done_err);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) $display("FAIL single_idle got=%b want=0", busy);
    else n_pass++;
  endtask

  task automatic test_three_node();
    int d0; bit to; logic [15:0] e, g;
    d0 = done_cnt;
    exp_q.push_back(16'h0011);
    exp_q.push_back(16'h0022);
    pulse_start(8'd0);
    wait_done(d0, to);
    n_chk++;
    if (to) $display("FAIL three_timeout got=no_done want=done");
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (got_q.size() == 0) $display("FAIL three_leaf got=none want=%h", e);
      else begin
        g = got_q.pop_front();
        if (g !== e) $display("FAIL three_leaf got=%h want=%h", g, e);
        else n_pass++;
      end
    end
    n_chk++;
    if (got_q.size() != 0) $display("FAIL three_extra got=%0d want=0", got_q.size());
    else n_pass++;
    n_chk++;
    if (done_visited !== exp_cnt(3)) $display("FAIL three_cnt got=%0d want=%0d", done_visited, exp_cnt(3));
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int d0, c, a0; bit to; logic [15:0] e, g;
    d0 = done_cnt;
    exp_q.push_back(16'h0011);
    exp_q.push_back(16'h0022);
    @(posedge clk); #1 leaf_ready = 1'b0;
    pulse_start(8'd0);
    c = 0;
    @(negedge clk);
    while (!leaf_valid && c < 500) begin
      @(negedge clk);
      c++;
    end
    n_chk++;
    if (!leaf_valid) $display("FAIL bp_no_leaf got=0 want=1");
    else n_pass++;
    a0 = act_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if (leaf_valid !== 1'b1 || leaf_rule !== 16'h0011)
        $display("FAIL bp_hold cyc=%0d got=%b/%h want=1/0011", i, leaf_valid, leaf_rule);
      else n_pass++;
    end
    n_chk++;
    if (act_cnt != a0) $display("FAIL bp_activity got=%0d want=0", act_cnt - a0);
    else n_pass++;
    @(posedge clk); #1 leaf_ready = 1'b1;
    wait_done(d0, to);
    n_chk++;
    if (to) $display("FAIL bp_timeout got=no_done want=done");
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (got_q.size() == 0) $display("FAIL bp_leaf got=none want=%h", e);
      else begin
        g = got_q.pop_front();
        if (g !== e) $display("FAIL bp_leaf got=%h want=%h", g, e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_overflow();
    int d0; bit to;
    d0 = done_cnt;
    depth = 2;
    // 10 -> (L11, R12), 11 -> (L13, R14): the left child of 11 finds the stack full.
    pulse_start(8'd10);
    wait_done(d0, to);
    n_chk++;
    if (to) $display("FAIL ovf_timeout got=no_done want=done");
    else n_pass++;
    n_chk++;
    if (done_err !== 1'b1) $display("FAIL ovf_err got=%b want=1", done_err);
    else n_pass++;
    n_chk++;
    if (full_push_viol != 0) $display("FAIL ovf_push_full got=%0d want=0", full_push_viol);
    else n_pass++;
    n_chk++;
    if (got_q.size() != 0) $display("FAIL ovf_leaves got=%0d want=0", got_q.size());
    else n_pass++;
    n_chk++;
    if (done_visited !== exp_cnt(2)) $display("FAIL ovf_cnt got=%0d want=%0d", done_visited, exp_cnt(2));
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (err_overflow !== 1'b1) $display("FAIL ovf_sticky got=%b want=1", err_overflow);
    else n_pass++;
    depth = 8;
    apply_reset();
  endtask

  task automatic test_reset_mid_walk();
    int d0, c; bit to; logic [15:0] e, g;
    pulse_start(8'd0);
    c = 0;
    @(negedge clk);
    while (!mem_req && c < 500) begin
      @(negedge clk);
      c++;
    end
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({busy, stk_push, stk_pop, stk_wdata, mem_req, mem_idx, leaf_valid, leaf_rule,
         done, err_overflow, visited_cnt} !== '0)
      $display("FAIL midrst_outputs busy=%b req=%b lv=%b cnt=%h want all 0", busy, mem_req, leaf_valid, visited_cnt);
    else n_pass++;
    @(posedge clk); #1 reset = 1'b1;
    n_chk++;
    if (got_q.size() != 0) $display("FAIL midrst_leaves got=%0d want=0", got_q.size());
    else n_pass++;
    d0 = done_cnt;
    exp_q.push_back(16'h0011);
    exp_q.push_back(16'h0022);
    pulse_start(8'd0);
    wait_done(d0, to);
    n_chk++;
    if (to) $display("FAIL midrst_timeout got=no_done want=done");
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (got_q.size() == 0) $display("FAIL midrst_leaf got=none want=%h", e);
      else begin
        g = got_q.pop_front();
        if (g !== e) $display("FAIL midrst_leaf got=%h want=%h", g, e);
        else n_pass++;
      end
    end
    n_chk++;
    if (done_visited !== exp_cnt(3)) $display("FAIL midrst_cnt got=%0d want=%0d", done_visited, exp_cnt(3));
    else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int d0; bit to; logic [15:0] e, g;
    d0 = done_cnt;
    exp_q.push_back(16'h0011);
    exp_q.push_back(16'h0022);
    pulse_start(8'd0);
    repeat (3) @(posedge clk);
    pulse_start(8'd3);
    repeat (4) @(posedge clk);
    pulse_start(8'd3);
    wait_done(d0, to);
    n_chk++;
    if (to) $display("FAIL busy_timeout got=no_done want=done");
    else n_pass++;
    repeat (30) @(posedge clk);
    n_chk++;
    if (done_cnt != d0 + 1) $display("FAIL busy_done_count got=%0d want=%0d", done_cnt - d0, 1);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (got_q.size() == 0) $display("FAIL busy_leaf got=none want=%h", e);
      else begin
        g = got_q.pop_front();
        if (g !== e) $display("FAIL busy_leaf got=%h want=%h", g, e);
        else n_pass++;
      end
    end
    n_chk++;
    if (got_q.size() != 0) $display("FAIL busy_extra got=%0d want=0", got_q.size());
    else n_pass++;
    n_chk++;
    if (done_visited !== exp_cnt(3)) $display("FAIL busy_cnt got=%0d want=%0d", done_visited, exp_cnt(3));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d0; bit to; logic [15:0] e, g;
    d0 = done_cnt;
    exp_q.push_back(16'h00AA);
    exp_q.push_back(16'h0011);
    exp_q.push_back(16'h0022);
    pulse_start(8'd3);
    wait_done(d0, to);
    pulse_start(8'd0);
    wait_done(d0 + 1, to);
    n_chk++;
    if (to || done_cnt != d0 + 2) $display("FAIL b2b_done got=%0d want=2", done_cnt - d0);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (got_q.size() == 0) $display("FAIL b2b_leaf got=none want=%h", e);
      else begin
        g = got_q.pop_front();
        if (g !== e) $display("FAIL b2b_leaf got=%h want=%h", g, e);
        else n_pass++;
      end
    end
    n_chk++;
    if (done_visited !== exp_cnt(3)) $display("FAIL b2b_cnt got=%0d want=%0d", done_visited, exp_cnt(3));
    else n_pass++;
  endtask

  task automatic test_invariants();
    n_chk++;
    if (both_viol != 0) $display("FAIL push_and_pop got=%0d want=0", both_viol);
    else n_pass++;
    n_chk++;
    if (out_viol != 0) $display("FAIL mem_outstanding got=%0d want=0", out_viol);
    else n_pass++;
    n_chk++;
    if (done_dbl != 0) $display("FAIL done_width got=%0d want=0", done_dbl);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) node_mem[i] = mk_node(1'b1, 8'd0, 8'd0, 16'hDEAD);
    node_mem[3]  = mk_node(1'b1, 8'd0,  8'd0,  16'h00AA);
    node_mem[0]  = mk_node(1'b0, 8'd1,  8'd2,  16'h0000);
    node_mem[1]  = mk_node(1'b1, 8'd0,  8'd0,  16'h0011);
    node_mem[2]  = mk_node(1'b1, 8'd0,  8'd0,  16'h0022);
    node_mem[10] = mk_node(1'b0, 8'd11, 8'd12, 16'h0000);
    node_mem[11] = mk_node(1'b0, 8'd13, 8'd14, 16'h0000);
    node_mem[12] = mk_node(1'b1, 8'd0,  8'd0,  16'h0C0C);
    node_mem[13] = mk_node(1'b1, 8'd0,  8'd0,  16'h0D0D);
    node_mem[14] = mk_node(1'b1, 8'd0,  8'd0,  16'h0E0E);

    test_reset();
    test_single_leaf();
    test_three_node();
    test_backpressure();
    test_overflow();
    test_reset_mid_walk();
    test_start_while_busy();
    test_back_to_back();
    test_invariants();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
